// File: rtl/trigger_io_if.sv
// rtl/trigger_io_if.sv - button/trigger and a0 display signal bundle for trigger_io
interface trigger_io_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  btn_raw;
  logic                  trigger;
  logic                  armed;
  logic [DATA_WIDTH-1:0] a0;
  logic [DATA_WIDTH-1:0] a0_out;
  logic                  a0_valid;
  logic [15:0]           a0_changes;

  modport master (
    output btn_raw, a0,
    input  trigger, armed, a0_out, a0_valid, a0_changes
  );

  modport slave (
    input  btn_raw, a0,
    output trigger, armed, a0_out, a0_valid, a0_changes
  );
endinterface

// File: rtl/trigger_io.sv
// rtl/trigger_io.sv - debounced one-shot trigger pulse and a0 change monitor
module trigger_io #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int DATA_WIDTH      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  trigger_io_if.slave io
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_FIRE     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  a0_out_q, a0_out_d;
  logic                   a0_valid_q, a0_valid_d;
  logic [15:0]            a0_changes_q, a0_changes_d;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      a0_out_q     <= '0;
      a0_valid_q   <= 1'b0;
      a0_changes_q <= '0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a0_out_q     <= a0_out_d;
      a0_valid_q   <= a0_valid_d;
      a0_changes_q <= a0_changes_d;
    end
  end

  // A press fires once; RELEASE holds until the button has been stably up.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], io.btn_raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (btn_s) begin
          state_d = S_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      S_DEBOUNCE: begin
        if (!btn_s) begin
          state_d = S_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_FIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIRE: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (btn_s) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a0_out_d     = a0_out_q;
    a0_valid_d   = 1'b0;
    a0_changes_d = a0_changes_q;
    if (io.a0 != a0_out_q) begin
      a0_out_d     = io.a0;
      a0_valid_d   = 1'b1;
      a0_changes_d = a0_changes_q + 16'd1;
    end
  end

  assign io.trigger    = (state_q == S_FIRE);
  assign io.armed      = (state_q == S_IDLE);
  assign io.a0_out     = a0_out_q;
  assign io.a0_valid   = a0_valid_q;
  assign io.a0_changes = a0_changes_q;

endmodule

// File: tb/tb_trigger_io.sv
// tb/tb_trigger_io.sv - directed bench for trigger_io, default and short-timing instances
module tb_trigger_io;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  int   sm_pulses;
  int   sm_width;
  logic sm_prev;
  logic sm_saw;

  always #5 clk = ~clk;

  trigger_io_if #(.DATA_WIDTH(32)) if_def ();
  trigger_io_if #(.DATA_WIDTH(32)) if_sm ();

  trigger_io #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .HOLD_CYCLES(64), .DATA_WIDTH(32)
  ) dut_def (
    .clk(clk), .rst_n(rst_n), .io(if_def)
  );

  trigger_io #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .DATA_WIDTH(32)
  ) dut_sm (
    .clk(clk), .rst_n(rst_n), .io(if_sm)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] a0_val);
    if_def.a0 = a0_val;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    if_def.btn_raw = 1'b1;
    if_def.a0      = 32'h5;
    if_sm.btn_raw  = 1'b0;
    if_sm.a0       = 32'h0;
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (if_def.trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger got=%b exp=0", if_def.trigger); end
    checks++;
    if (if_def.armed !== 1'b1) begin errors++; $display("FAIL reset_armed got=%b exp=1", if_def.armed); end
    checks++;
    if (if_def.a0_out !== 32'h0) begin errors++; $display("FAIL reset_a0_out got=%h exp=0", if_def.a0_out); end
    checks++;
    if (if_def.a0_changes !== 16'h0) begin errors++; $display("FAIL reset_changes got=%h exp=0", if_def.a0_changes); end
    rst_n = 1'b1;
    step();
    checks++;
    if (if_def.a0_out !== 32'h5) begin errors++; $display("FAIL post_reset_a0_out got=%h exp=5", if_def.a0_out); end
    checks++;
    if (if_def.a0_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid got=%b exp=1", if_def.a0_valid); end
    checks++;
    if (if_def.a0_changes !== 16'h1) begin errors++; $display("FAIL post_reset_changes got=%h exp=1", if_def.a0_changes); end
    if_def.btn_raw = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_hold_default();
    int   rise_edge = 0;
    int   fall_edge = 0;
    int   rises = 0;
    int   high_cnt = 0;
    logic prev = 1'b0;
    if_def.btn_raw = 1'b1;
    for (int n = 1; n <= 583; n++) begin
      step();
      if (if_def.trigger && !prev) begin
        rises++;
        if (rises == 1) rise_edge = n;
      end
      if (!if_def.trigger && prev) fall_edge = n;
      if (if_def.trigger) high_cnt++;
      prev = if_def.trigger;
    end
    checks++;
    if (rise_edge != 19) begin errors++; $display("FAIL hold_rise_edge got=%0d exp=19", rise_edge); end
    checks++;
    if (fall_edge != 83) begin errors++; $display("FAIL hold_fall_edge got=%0d exp=83", fall_edge); end
    checks++;
    if (rises != 1) begin errors++; $display("FAIL hold_pulse_count got=%0d exp=1", rises); end
    checks++;
    if (high_cnt != 64) begin errors++; $display("FAIL hold_width got=%0d exp=64", high_cnt); end
    if_def.btn_raw = 1'b0;
    repeat (30) step();
  endtask

  task automatic test_glitch();
    logic saw = 1'b0;
    for (int g = 0; g < 5; g++) begin
      if_sm.btn_raw = 1'b1;
      repeat (3) begin
        step();
        if (if_sm.trigger) saw = 1'b1;
      end
      if_sm.btn_raw = 1'b0;
      repeat (6) begin
        step();
        if (if_sm.trigger) saw = 1'b1;
      end
      checks++;
      if (if_sm.armed !== 1'b1) begin errors++; $display("FAIL glitch_armed[%0d] got=%b exp=1", g, if_sm.armed); end
    end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL glitch_trigger got=%b exp=0", saw); end
  endtask

  task automatic run_sm(input logic b, input int n);
    if_sm.btn_raw = b;
    repeat (n) begin
      step();
      if (if_sm.trigger) begin
        if (!sm_prev) sm_pulses++;
        sm_width++;
      end else if (sm_prev) begin
        checks++;
        if (sm_width != 8) begin errors++; $display("FAIL sm_pulse_width got=%0d exp=8", sm_width); end
        sm_width = 0;
      end
      sm_prev = if_sm.trigger;
    end
  endtask

  task automatic test_back_to_back();
    sm_pulses = 0;
    sm_width  = 0;
    sm_prev   = 1'b0;
    run_sm(1'b1, 20);
    run_sm(1'b0, 2);
    run_sm(1'b1, 30);
    checks++;
    if (sm_pulses != 1) begin errors++; $display("FAIL short_release_pulses got=%0d exp=1", sm_pulses); end
    run_sm(1'b0, 10);
    run_sm(1'b1, 20);
    run_sm(1'b0, 10);
    checks++;
    if (sm_pulses != 2) begin errors++; $display("FAIL full_cycle_pulses got=%0d exp=2", sm_pulses); end
  endtask

  task automatic test_a0_sequence();
    logic [31:0] seq [5];
    logic        vexp [5];
    seq[0] = 32'h0; seq[1] = 32'hA; seq[2] = 32'hA; seq[3] = 32'hB; seq[4] = 32'hA;
    vexp[0] = 1'b0; vexp[1] = 1'b1; vexp[2] = 1'b0; vexp[3] = 1'b1; vexp[4] = 1'b1;
    do_reset(32'h0);
    for (int i = 0; i < 5; i++) begin
      if_def.a0 = seq[i];
      step();
      checks++;
      if (if_def.a0_valid !== vexp[i]) begin errors++; $display("FAIL a0_valid[%0d] got=%b exp=%b", i, if_def.a0_valid, vexp[i]); end
    end
    checks++;
    if (if_def.a0_changes !== 16'd3) begin errors++; $display("FAIL a0_changes got=%0d exp=3", if_def.a0_changes); end
    checks++;
    if (if_def.a0_out !== 32'hA) begin errors++; $display("FAIL a0_out_final got=%h exp=A", if_def.a0_out); end
  endtask

  task automatic test_wrap();
    logic [31:0] v = 32'h0;
    do_reset(32'h0);
    for (int i = 0; i < 65535; i++) begin
      v = v ^ 32'h1;
      if_def.a0 = v;
      step();
    end
    checks++;
    if (if_def.a0_changes !== 16'hFFFF) begin errors++; $display("FAIL preload_changes got=%h exp=FFFF", if_def.a0_changes); end
    if_def.a0 = v ^ 32'h1;
    step();
    checks++;
    if (if_def.a0_changes !== 16'h0000) begin errors++; $display("FAIL wrap_changes got=%h exp=0000", if_def.a0_changes); end
    checks++;
    if (if_def.a0_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%b exp=1", if_def.a0_valid); end
  endtask

  task automatic test_async_reset();
    int rise_edge = 0;
    do_reset(32'h0);
    if_def.btn_raw = 1'b1;
    repeat (30) step();
    checks++;
    if (if_def.trigger !== 1'b1) begin errors++; $display("FAIL mid_fire_trigger got=%b exp=1", if_def.trigger); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_def.trigger !== 1'b0) begin errors++; $display("FAIL async_drop_trigger got=%b exp=0", if_def.trigger); end
    checks++;
    if (if_def.armed !== 1'b1) begin errors++; $display("FAIL async_armed got=%b exp=1", if_def.armed); end
    step();
    rst_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (if_def.trigger && rise_edge == 0) rise_edge = n;
    end
    checks++;
    if (rise_edge != 19) begin errors++; $display("FAIL held_after_reset_rise got=%0d exp=19", rise_edge); end
    if_def.btn_raw = 1'b0;
  endtask

  initial begin
    if_def.btn_raw = 1'b0;
    if_def.a0      = 32'h0;
    if_sm.btn_raw  = 1'b0;
    if_sm.a0       = 32'h0;
    test_reset();
    test_hold_default();
    test_glitch();
    test_back_to_back();
    test_a0_sequence();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
